// File: rtl/seg_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | seg_pkg: segment codes and decode types shared by display TX and RX  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package seg_pkg;

  localparam int c_NUM_DIGITS = 6;

  // Common-anode, active-low g..a patterns for hex values 0..F
  localparam logic [6:0] c_SEG_CODE [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  localparam logic [6:0] c_SEG_BLANK = 7'h7F;

  typedef struct packed {
    logic [3:0] value;
    logic       hit;
    logic       blank;
  } seg_dec_t;

endpackage
`default_nettype wire

// File: rtl/seg_code_lut.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | seg_code_lut: 7-bit segment pattern to hex value plus hit/blank      |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module seg_code_lut
  import seg_pkg::*;
(
  input  logic [6:0] code_i,
  output seg_dec_t   dec_o
);

  always_comb begin
    dec_o = '0;
    for (int i = 0; i < 16; i++) begin
      if (code_i == c_SEG_CODE[i]) begin
        dec_o.value = 4'(i);
        dec_o.hit   = 1'b1;
      end
    end
    dec_o.blank = (code_i == c_SEG_BLANK);
  end

endmodule
`default_nettype wire

// File: rtl/seg_scan_decoder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | seg_scan_decoder: debounced capture of a scanned 6-digit 7-seg bus   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module seg_scan_decoder
  import seg_pkg::*;
#(
  parameter int STABLE_CNT = 4
) (
  input  logic                      sys_clk,
  input  logic                      sys_rst_n,
  input  logic [7:0]                dig_duan,
  input  logic [5:0]                dig_wei,
  output logic [4*c_NUM_DIGITS-1:0] digits,
  output logic [c_NUM_DIGITS-1:0]   dp,
  output logic [c_NUM_DIGITS-1:0]   digit_valid,
  output logic [c_NUM_DIGITS-1:0]   code_err,
  output logic                      upd,
  output logic                      sel_err
);

  localparam logic [7:0] c_STABLE = 8'(STABLE_CNT);

  logic [7:0]                duan_m_q, duan_s_q;
  logic [5:0]                wei_m_q, wei_s_q;
  logic                      vld_m_q, vld_s_q;
  logic [13:0]               prev_q;
  logic [7:0]                cnt_q, cnt_d;
  logic [4*c_NUM_DIGITS-1:0] digits_q, digits_d;
  logic [c_NUM_DIGITS-1:0]   dp_q, dp_d;
  logic [c_NUM_DIGITS-1:0]   valid_q, valid_d;
  logic [c_NUM_DIGITS-1:0]   err_q, err_d;
  logic                      upd_q, sel_err_q;

  logic [13:0] w_sample;
  logic        w_restart;
  logic        w_fire;
  logic [5:0]  w_sel;
  logic        w_one_hot;
  logic        w_cap_one;
  logic        w_cap_multi;
  seg_dec_t    w_dec;

  seg_code_lut u_lut (
    .code_i (duan_s_q[6:0]),
    .dec_o  (w_dec)
  );

  assign w_sample  = {wei_s_q, duan_s_q};
  assign w_restart = (cnt_q == 8'd0) || (w_sample != prev_q);
  assign w_sel     = ~wei_s_q;
  assign w_one_hot = (w_sel != 6'd0) && ((w_sel & (w_sel - 6'd1)) == 6'd0);

  // The valid pipeline keeps reset-value samples out of the first run.
  always_comb begin
    cnt_d = cnt_q;
    if (!vld_s_q)
      cnt_d = 8'd0;
    else if (w_restart)
      cnt_d = 8'd1;
    else if (cnt_q != 8'hFF)
      cnt_d = cnt_q + 8'd1;
  end

  // Fire only on the transition into STABLE_CNT so a saturated run stays quiet.
  assign w_fire      = vld_s_q && (cnt_d == c_STABLE) && (w_restart || (cnt_q != cnt_d));
  assign w_cap_one   = w_fire && w_one_hot;
  assign w_cap_multi = w_fire && (w_sel != 6'd0) && !w_one_hot;

  always_comb begin
    digits_d = digits_q;
    dp_d     = dp_q;
    valid_d  = valid_q;
    err_d    = err_q;
    for (int i = 0; i < c_NUM_DIGITS; i++) begin
      if (w_cap_one && w_sel[i]) begin
        if (w_dec.hit) begin
          digits_d[4*i +: 4] = w_dec.value;
          dp_d[i]            = ~duan_s_q[7];
          valid_d[i]         = 1'b1;
          err_d[i]           = 1'b0;
        end else if (w_dec.blank) begin
          dp_d[i]    = ~duan_s_q[7];
          valid_d[i] = 1'b0;
          err_d[i]   = 1'b0;
        end else begin
          valid_d[i] = 1'b0;
          err_d[i]   = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      duan_m_q  <= '0;
      duan_s_q  <= '0;
      wei_m_q   <= '0;
      wei_s_q   <= '0;
      vld_m_q   <= 1'b0;
      vld_s_q   <= 1'b0;
      prev_q    <= '0;
      cnt_q     <= '0;
      digits_q  <= '0;
      dp_q      <= '0;
      valid_q   <= '0;
      err_q     <= '0;
      upd_q     <= 1'b0;
      sel_err_q <= 1'b0;
    end else begin
      duan_m_q  <= dig_duan;
      duan_s_q  <= duan_m_q;
      wei_m_q   <= dig_wei;
      wei_s_q   <= wei_m_q;
      vld_m_q   <= 1'b1;
      vld_s_q   <= vld_m_q;
      prev_q    <= w_sample;
      cnt_q     <= cnt_d;
      digits_q  <= digits_d;
      dp_q      <= dp_d;
      valid_q   <= valid_d;
      err_q     <= err_d;
      upd_q     <= w_cap_one;
      sel_err_q <= w_cap_multi;
    end
  end

  assign digits      = digits_q;
  assign dp          = dp_q;
  assign digit_valid = valid_q;
  assign code_err    = err_q;
  assign upd         = upd_q;
  assign sel_err     = sel_err_q;

endmodule
`default_nettype wire

// File: tb/tb_seg_scan_decoder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_seg_scan_decoder: directed checks of capture, glitch and errors   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_seg_scan_decoder;

  logic        clk;
  logic        rst_n;
  logic [7:0]  duan;
  logic [5:0]  wei;
  logic [23:0] digits;
  logic [5:0]  dp;
  logic [5:0]  digit_valid;
  logic [5:0]  code_err;
  logic        upd;
  logic        sel_err;

  int errors;
  int checks;
  int upd_cnt;
  int sel_cnt;

  logic [6:0] seg_tab [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  seg_scan_decoder #(.STABLE_CNT(4)) dut (
    .sys_clk     (clk),
    .sys_rst_n   (rst_n),
    .dig_duan    (duan),
    .dig_wei     (wei),
    .digits      (digits),
    .dp          (dp),
    .digit_valid (digit_valid),
    .code_err    (code_err),
    .upd         (upd),
    .sel_err     (sel_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse counters sample just after each active edge.
  always @(posedge clk) begin
    #2;
    if (upd === 1'b1) upd_cnt++;
    if (sel_err === 1'b1) sel_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_digits"}, 32'(digits), 32'h0);
    check({tag, "_dp"}, 32'(dp), 32'h0);
    check({tag, "_valid"}, 32'(digit_valid), 32'h0);
    check({tag, "_err"}, 32'(code_err), 32'h0);
    check({tag, "_upd"}, 32'(upd), 32'h0);
    check({tag, "_selerr"}, 32'(sel_err), 32'h0);
  endtask

  initial begin
    logic [5:0] w;
    errors  = 0;
    checks  = 0;
    upd_cnt = 0;
    sel_cnt = 0;
    rst_n   = 1'b0;
    wei     = 6'h3F;
    duan    = 8'hFF;

    // Reset with random bus activity
    repeat (6) begin
      @(negedge clk);
      wei  = 6'($urandom);
      duan = 8'($urandom);
    end
    wait_n(1);
    check_all_zero("reset");

    wei  = 6'h3F;
    duan = 8'hFF;
    rst_n = 1'b1;
    wait_n(10);
    check_all_zero("idle");
    check("idle_upd_cnt", 32'(upd_cnt), 32'd0);
    check("idle_sel_cnt", 32'(sel_cnt), 32'd0);

    // Digit 0 shows "1", dp off
    upd_cnt = 0;
    wei  = 6'b111110;
    duan = 8'hF9;
    wait_n(5);
    check("d0_pre_valid", 32'(digit_valid), 32'h0);
    wait_n(1);
    check("d0_digits", 32'(digits[3:0]), 32'h1);
    check("d0_valid", 32'(digit_valid), 32'b000001);
    check("d0_dp", 32'(dp), 32'h0);
    check("d0_upd", 32'(upd), 32'h1);
    wait_n(6);
    check("d0_upd_once", 32'(upd_cnt), 32'd1);

    // Digit 5 shows "8" with dp lit
    wei  = 6'b011111;
    duan = 8'h00;
    wait_n(6);
    check("d5_digits", 32'(digits), 32'h800001);
    check("d5_dp", 32'(dp), 32'b100000);
    check("d5_valid", 32'(digit_valid), 32'b100001);

    // Short run of "2" must be ignored, then "3" captured
    upd_cnt = 0;
    wei  = 6'b111110;
    duan = 8'hA4;
    wait_n(3);
    duan = 8'hB0;
    wait_n(5);
    check("glitch_no_upd", 32'(upd_cnt), 32'd0);
    check("glitch_digits_kept", 32'(digits), 32'h800001);
    wait_n(1);
    check("glitch_digits_3", 32'(digits), 32'h800003);
    wait_n(4);
    check("glitch_upd_once", 32'(upd_cnt), 32'd1);

    // Multi-select
    upd_cnt = 0;
    sel_cnt = 0;
    wei  = 6'b111100;
    wait_n(10);
    check("multi_sel_cnt", 32'(sel_cnt), 32'd1);
    check("multi_upd_cnt", 32'(upd_cnt), 32'd0);
    check("multi_digits", 32'(digits), 32'h800003);
    check("multi_valid", 32'(digit_valid), 32'b100001);

    // Unknown pattern on digit 0
    upd_cnt = 0;
    wei  = 6'b111110;
    duan = 8'hAA;
    wait_n(8);
    check("bad_err", 32'(code_err), 32'b000001);
    check("bad_valid", 32'(digit_valid), 32'b100000);
    check("bad_digits", 32'(digits), 32'h800003);
    check("bad_dp", 32'(dp), 32'b100000);
    check("bad_upd_cnt", 32'(upd_cnt), 32'd1);

    // Blank on digit 0
    duan = 8'hFF;
    wait_n(8);
    check("blank_err", 32'(code_err), 32'h0);
    check("blank_valid", 32'(digit_valid), 32'b100000);
    check("blank_dp", 32'(dp), 32'b100000);

    // Full scan of values 0..5
    upd_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      w    = 6'h3F;
      w[i] = 1'b0;
      wei  = w;
      duan = {1'b1, seg_tab[i]};
      wait_n(8);
    end
    check("scan_digits", 32'(digits), 32'h543210);
    check("scan_valid", 32'(digit_valid), 32'h3F);
    check("scan_dp", 32'(dp), 32'h0);
    check("scan_err", 32'(code_err), 32'h0);
    check("scan_upd_cnt", 32'(upd_cnt), 32'd6);

    // Reset pulse in the middle of a scan, then a fresh run
    for (int i = 0; i < 3; i++) begin
      w    = 6'h3F;
      w[i] = 1'b0;
      wei  = w;
      duan = {1'b1, seg_tab[9 + i]};
      wait_n(i < 2 ? 8 : 3);
    end
    #2 rst_n = 1'b0;
    #1;
    check_all_zero("midreset");
    wait_n(2);
    upd_cnt = 0;
    rst_n = 1'b1;
    wait_n(5);
    check("rerun_pre_valid", 32'(digit_valid), 32'h0);
    check("rerun_pre_upd", 32'(upd_cnt), 32'd0);
    wait_n(1);
    check("rerun_digits", 32'(digits), 32'h000B00);
    check("rerun_valid", 32'(digit_valid), 32'b000100);
    check("rerun_upd", 32'(upd), 32'h1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
